mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port with one outstanding access.
// Data has priority; fetch is forced through after STARVE_MAX consecutive data grants.
module mem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             win_if;
    logic             win_dm;
    logic             starved;

    assign starved = (starve_q == CNT_W'(STARVE_MAX));

    // Arbitration: only in IDLE and never while reset is asserted
    always_comb begin
        win_if = 1'b0;
        win_dm = 1'b0;
        if (!reset && (state_q == IDLE)) begin
            if (if_req && (!dm_req || starved)) begin
                win_if = 1'b1;
            end else if (dm_req) begin
                win_dm = 1'b1;
            end
        end
    end

    always_comb begin
        mem_req   = win_if | win_dm;
        mem_we    = win_dm & dm_we;
        mem_addr  = win_dm ? dm_addr : (win_if ? if_addr : '0);
        mem_wdata = win_dm ? dm_wdata : '0;
        mem_be    = win_dm ? dm_be : '0;
        if_gnt    = win_if & mem_gnt;
        dm_gnt    = win_dm & mem_gnt;
        if_rvalid = !reset && (state_q == WAIT_IF) && mem_rvalid;
        dm_rvalid = !reset && (state_q == WAIT_DM) && mem_rvalid;
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        busy      = !reset && (state_q != IDLE);
    end

    // Starvation counter: data grants seen while fetch keeps waiting
    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (dm_gnt && !starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (if_gnt) begin
                        state_q <= WAIT_IF;
                    end else if (dm_gnt) begin
                        state_q <= WAIT_DM;
                    end
                end
                WAIT_IF, WAIT_DM: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, starvation sequence, then
// randomized traffic against a grant-history reference model.
module tb_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [3:0]    dm_be;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_be;
    logic          busy;

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        rst, ifr;
        logic [31:0] ifa;
        logic        dmr, we;
        logic [31:0] dma, wd;
        logic [3:0]  be;
        logic        mg, mrv;
        logic [31:0] mrd;
        logic        e_mreq, e_ifg, e_dmg, e_ifv, e_dmv, e_busy;
        logic [31:0] e_maddr;
        logic        e_mwe;
        logic [31:0] e_mwd;
        logic [3:0]  e_mbe;
    } vec_t;

    task automatic drive(input logic rst, input logic ifr, input logic [31:0] ifa,
                         input logic dmr, input logic we, input logic [31:0] dma,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic mg, input logic mrv, input logic [31:0] mrd);
        @(negedge clk);
        reset = rst; if_req = ifr; if_addr = ifa;
        dm_req = dmr; dm_we = we; dm_addr = dma; dm_wdata = wd; dm_be = be;
        mem_gnt = mg; mem_rvalid = mrv; mem_rdata = mrd;
        #2;
    endtask

    vec_t tbl[$];
    int   glog[$];
    int   exp_g[6] = '{2, 2, 2, 2, 1, 2};

    // Reference model state for the random phase
    int          owner;
    int          hist[$];
    logic        if_pend, dm_pend, d_we;
    logic [31:0] if_a, d_a, d_wd;
    logic [3:0]  d_be;

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; dm_be = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        tbl.push_back('{1,1,32'h100,1,0,32'h2000,0,0,1,0,0, 0,0,0,0,0,0, 0,0,0,0});
        tbl.push_back('{1,1,32'h100,1,0,32'h2000,0,0,1,1,0, 0,0,0,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,32'h100,0,0,0,0,0,1,0,0, 1,1,0,0,0,0, 32'h100,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0,0,1,32'h00500093, 0,0,0,1,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,32'h300,1,0,32'h2000,0,0,1,0,0, 1,0,1,0,0,0, 32'h2000,0,0,0});
        tbl.push_back('{0,1,32'h300,0,0,0,0,0,1,1,32'h1234, 0,0,0,0,1,1, 0,0,0,0});
        tbl.push_back('{0,1,32'h300,0,0,0,0,0,1,0,0, 1,1,0,0,0,0, 32'h300,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0,0,1,32'h5555, 0,0,0,1,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,1,1,32'h40,32'hDEADBEEF,4'b0011,1,0,0, 1,0,1,0,0,0, 32'h40,1,32'hDEADBEEF,4'b0011});
        tbl.push_back('{0,0,0,0,0,0,0,0,0,1,32'hABCD, 0,0,0,0,1,1, 0,0,0,0});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0,1,32'h500,0,0,0,0,0,0,0,0, 1,0,0,0,0,0, 32'h500,0,0,0});
        tbl.push_back('{0,1,32'h500,0,0,0,0,0,1,0,0, 1,1,0,0,0,0, 32'h500,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0,0,1,32'h77, 0,0,0,1,0,1, 0,0,0,0});
        tbl.push_back('{0,0,0,0,0,0,0,0,1,1,32'h88, 0,0,0,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,32'h600,1,0,32'h80,0,0,1,0,0, 1,0,1,0,0,0, 32'h80,0,0,0});
        tbl.push_back('{1,1,32'h600,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0});
        tbl.push_back('{0,1,32'h600,0,0,0,0,0,0,0,0, 1,0,0,0,0,0, 32'h600,0,0,0});
        tbl.push_back('{0,1,32'h600,0,0,0,0,0,0,1,32'h99, 1,0,0,0,0,0, 32'h600,0,0,0});

        foreach (tbl[k]) begin
            vec_t v;
            v = tbl[k];
            drive(v.rst, v.ifr, v.ifa, v.dmr, v.we, v.dma, v.wd, v.be, v.mg, v.mrv, v.mrd);
            check($sformatf("tbl%0d_ctrl", k),
                  128'({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy}),
                  128'({v.e_mreq, v.e_ifg, v.e_dmg, v.e_ifv, v.e_dmv, v.e_busy}));
            if (v.e_mreq)
                check($sformatf("tbl%0d_mem", k), 128'({mem_we, mem_addr, mem_be}),
                      128'({v.e_mwe, v.e_maddr, v.e_mbe}));
            if (v.e_mwe)
                check($sformatf("tbl%0d_wdata", k), 128'(mem_wdata), 128'(v.e_mwd));
            if (v.e_ifv) check($sformatf("tbl%0d_ifrdata", k), 128'(if_rdata), 128'(v.mrd));
            if (v.e_dmv) check($sformatf("tbl%0d_dmrdata", k), 128'(dm_rdata), 128'(v.mrd));
        end

        // Starvation: both held, memory grants and answers immediately; counter starts cleared by the reset above
        for (int c = 0; c < 12; c++) begin
            drive(0, 1, 32'h600, 1, 0, 32'h900, 0, 0, 1, 1, $urandom);
            if (if_gnt) glog.push_back(1);
            if (dm_gnt) glog.push_back(2);
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("starve_grant%0d", i),
                  128'((i < glog.size()) ? glog[i] : 0), 128'(exp_g[i]));

        // Randomized traffic
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        owner = 0; hist.delete(); if_pend = 0; dm_pend = 0;
        if_a = 0; d_a = 0; d_wd = 0; d_be = 0; d_we = 0;
        for (int c = 0; c < 600; c++) begin
            logic rst, mg, mrv, go_if, go_dm, e_ifg, e_dmg, e_ifv, e_dmv, e_busy;
            logic [31:0] mrd;
            rst = ($urandom_range(0, 63) == 0);
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_a = $urandom;
            end
            if (!dm_pend && $urandom_range(0, 1) == 0) begin
                dm_pend = 1; d_a = $urandom; d_wd = $urandom;
                d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
            end
            mg  = ($urandom_range(0, 3) != 0);
            mrv = 1'($urandom_range(0, 1));
            mrd = $urandom;
            drive(rst, if_pend, if_a, dm_pend, d_we, d_a, d_wd, d_be, mg, mrv, mrd);

            go_if = !rst && owner == 0 && if_pend && (!dm_pend || hist.size() >= SM);
            go_dm = !rst && owner == 0 && dm_pend && !go_if;
            e_ifg = go_if && mg;
            e_dmg = go_dm && mg;
            e_ifv = !rst && owner == 1 && mrv;
            e_dmv = !rst && owner == 2 && mrv;
            e_busy = !rst && owner != 0;
            check($sformatf("rnd%0d_ctrl", c),
                  128'({mem_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy}),
                  128'({go_if || go_dm, e_ifg, e_dmg, e_ifv, e_dmv, e_busy}));
            if (go_if)
                check($sformatf("rnd%0d_ifmem", c), 128'({mem_we, mem_addr, mem_be}),
                      128'({1'b0, if_a, 4'b0}));
            if (go_dm)
                check($sformatf("rnd%0d_dmmem", c), 128'({mem_we, mem_addr, mem_be, mem_wdata}),
                      128'({d_we, d_a, d_be, d_we ? d_wd : mem_wdata}));
            check($sformatf("rnd%0d_rdata", c), 128'({if_rdata, dm_rdata}), 128'({mrd, mrd}));

            if (rst) begin
                owner = 0; hist.delete();
            end else begin
                if (owner == 0) begin
                    if (e_ifg) owner = 1;
                    else if (e_dmg) owner = 2;
                end else if (mrv) begin
                    owner = 0;
                end
                if (!if_pend || e_ifg) hist.delete();
                else if (e_dmg && hist.size() < SM) hist.push_back(1);
            end
            if (e_ifg) if_pend = 0;
            if (e_dmg) dm_pend = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
